reg_write_arbiter: RTL and testbench



---
 rtl/reg_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_reg_write_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the single write port of a register bank between
// NUM_REQ requesters. Round-robin grant with an optional per-ownership hold
// limit (MAX_HOLD, 0 = unlimited). Every release passes through one IDLE cycle.
// Build option: define ARB_FIXED_PRIO_EN to replace round robin with fixed
// priority (lowest requesting index wins).
module reg_write_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned MAX_HOLD   = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_in,
    input  logic [NUM_REQ-1:0]            we_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          reg_we,
    output logic [ADDR_WIDTH-1:0]         reg_addr,
    output logic [DATA_WIDTH-1:0]         reg_wdata,
    output logic                          busy
);

    localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HCW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit             HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  grant_nxt;
    logic [HCW-1:0]      hold_cnt, hold_nxt;
    logic                pick_valid;
    logic [IDXW-1:0]     pick;
    logic                sel_req, sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

`ifndef ARB_FIXED_PRIO_EN
    logic [IDXW-1:0]     last_ptr;

    // Round-robin pick: first requester in cyclic order after last_ptr
    always_comb begin
        int unsigned idx;
        pick_valid = 1'b0;
        pick       = '0;
        idx        = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = 32'(last_ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_valid && req_in[IDXW'(idx)]) begin
                pick_valid = 1'b1;
                pick       = IDXW'(idx);
            end
        end
    end

    // Remember the most recent owner; it ranks last in the next arbitration
    always_ff @(posedge clock) begin
        if (reset)
            last_ptr <= IDXW'(NUM_REQ - 1);
        else if (state == IDLE && pick_valid)
            last_ptr <= pick;
    end
`else
    // Fixed-priority pick: scanning downwards leaves the lowest requester
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (req_in[IDXW'(i - 1)]) begin
                pick_valid = 1'b1;
                pick       = IDXW'(i - 1);
            end
        end
    end
`endif

    // Select the granted requester's signals; grant is zero outside OWN so all fall to 0
    always_comb begin
        sel_req   = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[IDXW'(i)]) begin
                sel_req   = req_in[IDXW'(i)];
                sel_we    = we_in[IDXW'(i)];
                sel_addr  = addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign reg_we    = (state == OWN) && sel_req && sel_we && !reset;
    assign reg_addr  = sel_addr;
    assign reg_wdata = sel_wdata;
    assign busy      = (state == OWN);

    // Next-state logic: grant from IDLE, release on request drop or hold limit
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt       = OWN;
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    hold_nxt        = '0;
                end
            end
            OWN: begin
                if (hold_cnt != '1) hold_nxt = hold_cnt + 1'b1;
                if (!sel_req || (HOLD_EN && hold_cnt == HOLD_LAST)) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State, grant and hold counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            hold_cnt <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter (NUM_REQ=3, MAX_HOLD=4).
// Stimulus pushes hand-computed per-cycle expectations and expected writes;
// a negedge monitor pops and compares.
module tb_reg_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req_in, we_in;
    logic [14:0] addr_in;
    logic [95:0] wdata_in;
    logic [2:0]  grant;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        busy;

    reg_write_arbiter #(
        .NUM_REQ(3), .DATA_WIDTH(32), .ADDR_WIDTH(5), .MAX_HOLD(4)
    ) dut (
        .clock(clock), .reset(reset), .req_in(req_in), .we_in(we_in),
        .addr_in(addr_in), .wdata_in(wdata_in), .grant(grant),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct { logic [2:0] g; logic we; } exp_t;
    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;

    exp_t expq[$];
    wr_t  wrq[$];
    exp_t mon_e;
    wr_t  mon_w;
    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [4:0]  a_of [3] = '{5'd5, 5'd9, 5'd7};
    logic [31:0] d_of [3] = '{32'hDEADBEEF, 32'h1111_1111, 32'h2222_2222};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus plus its expected grant and write strobe
    task automatic cyc(input logic rst, input logic [2:0] req, input logic [2:0] we,
                       input logic [2:0] eg, input logic ew);
        exp_t e;
        wr_t  w;
        @(posedge clock); #1;
        reset  = rst;
        req_in = req;
        we_in  = we;
        e.g  = eg;
        e.we = ew;
        expq.push_back(e);
        if (ew) begin
            for (int i = 0; i < 3; i++) begin
                if (eg[i]) begin
                    w.a = a_of[i];
                    w.d = d_of[i];
                    wrq.push_back(w);
                end
            end
        end
    endtask

    always @(negedge clock) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            check("grant", 32'(grant), 32'(mon_e.g));
            check("busy", 32'(busy), 32'(mon_e.g != 3'b000));
            check("reg_we", 32'(reg_we), 32'(mon_e.we));
            if (mon_e.g == 3'b000) begin
                check("idle_addr", 32'(reg_addr), 32'd0);
                check("idle_wdata", reg_wdata, 32'd0);
            end
        end
        if (reg_we === 1'b1) begin
            if (wrq.size() == 0) begin
                check("write_unexpected", 32'(reg_addr), 32'hFFFF_FFFF);
            end else begin
                mon_w = wrq.pop_front();
                check("write_addr", 32'(reg_addr), 32'(mon_w.a));
                check("write_data", reg_wdata, mon_w.d);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        req_in = '0;
        we_in  = '0;
        for (int i = 0; i < 3; i++) begin
            addr_in[i*5 +: 5]   = a_of[i];
            wdata_in[i*32 +: 32] = d_of[i];
        end
        @(posedge clock);

        // Single write path from reset
        cyc(1, 3'b000, 3'b000, 3'b000, 0);
        cyc(0, 3'b001, 3'b001, 3'b000, 0);
        repeat (3) cyc(0, 3'b001, 3'b001, 3'b001, 1);
        cyc(0, 3'b000, 3'b001, 3'b001, 0);
        cyc(0, 3'b000, 3'b000, 3'b000, 0);

`ifndef ARB_FIXED_PRIO_EN
        // Round robin with continuous requests, hold limit releases each owner
        cyc(1, 3'b000, 3'b000, 3'b000, 0);
        cyc(0, 3'b011, 3'b011, 3'b000, 0);
        repeat (4) cyc(0, 3'b011, 3'b011, 3'b001, 1);
        cyc(0, 3'b011, 3'b011, 3'b000, 0);
        repeat (4) cyc(0, 3'b011, 3'b011, 3'b010, 1);
        cyc(0, 3'b011, 3'b011, 3'b000, 0);
        repeat (4) cyc(0, 3'b111, 3'b111, 3'b001, 1);
        cyc(0, 3'b111, 3'b111, 3'b000, 0);
        repeat (4) cyc(0, 3'b111, 3'b111, 3'b010, 1);
        cyc(0, 3'b111, 3'b111, 3'b000, 0);
        repeat (4) cyc(0, 3'b111, 3'b111, 3'b100, 1);
        cyc(0, 3'b111, 3'b111, 3'b000, 0);
        cyc(0, 3'b000, 3'b000, 3'b001, 0);
        cyc(0, 3'b000, 3'b000, 3'b000, 0);

        // Hold limit: req0 held 12 cycles, req1 waiting then dropping
        cyc(1, 3'b000, 3'b000, 3'b000, 0);
        cyc(0, 3'b011, 3'b011, 3'b000, 0);
        repeat (4) cyc(0, 3'b011, 3'b011, 3'b001, 1);
        cyc(0, 3'b011, 3'b011, 3'b000, 0);
        repeat (2) cyc(0, 3'b011, 3'b011, 3'b010, 1);
        cyc(0, 3'b001, 3'b001, 3'b010, 0);
        cyc(0, 3'b001, 3'b001, 3'b000, 0);
        repeat (2) cyc(0, 3'b001, 3'b001, 3'b001, 1);
        cyc(0, 3'b000, 3'b000, 3'b001, 0);
        cyc(0, 3'b000, 3'b000, 3'b000, 0);
`endif

        // Reset mid-write, then contention between requesters 1 and 2
        cyc(0, 3'b001, 3'b001, 3'b000, 0);
        cyc(0, 3'b001, 3'b001, 3'b001, 1);
        cyc(1, 3'b001, 3'b001, 3'b001, 0);
        cyc(0, 3'b110, 3'b110, 3'b000, 0);
        cyc(0, 3'b110, 3'b110, 3'b010, 1);
        cyc(0, 3'b000, 3'b000, 3'b010, 0);
        cyc(0, 3'b000, 3'b000, 3'b000, 0);

        // Strobe gating: owner 0 has we=0, requester 2 drives we=1 at addr 7
        cyc(0, 3'b001, 3'b000, 3'b000, 0);
        repeat (3) cyc(0, 3'b101, 3'b100, 3'b001, 0);
        cyc(0, 3'b000, 3'b100, 3'b001, 0);
        cyc(0, 3'b000, 3'b000, 3'b000, 0);

`ifdef ARB_FIXED_PRIO_EN
        // Fixed priority: requester 0 wins every arbitration it enters
        cyc(1, 3'b000, 3'b000, 3'b000, 0);
        cyc(0, 3'b011, 3'b011, 3'b000, 0);
        repeat (3) begin
            cyc(0, 3'b011, 3'b011, 3'b001, 1);
            cyc(0, 3'b010, 3'b011, 3'b001, 0);
            cyc(0, 3'b011, 3'b011, 3'b000, 0);
        end
        cyc(0, 3'b000, 3'b000, 3'b001, 0);
        cyc(0, 3'b000, 3'b000, 3'b000, 0);
`endif

        @(negedge clock);
        @(negedge clock);
        check("scoreboard_drained", expq.size() + wrq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
